router_reg_p: RTL and testbench



---
 rtl/router_reg_p.sv | 176 +++++++++++++++++
 tb/tb_router_reg_p.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_p.sv
// router_reg_p -- register stage of the 1x3 router, placed between the router
// FSM and the output FIFOs. It latches the packet header, parks a payload word
// while the selected FIFO is full, accumulates the packet checksum and compares
// it with the trailing check word. It also checks the payload count against
// the header length field and keeps a saturating count of bad packets.
//
// Parameters:
//   DW          data/header/check word width (>= 4)
//   ADDR_W      header address field width; length field is data_in[DW-1:ADDR_W]
//   PARITY_MODE 0 = bitwise XOR checksum, 1 = sum modulo 2^DW
//   CNT_W       width of err_count
//
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   pkt_valid             source data valid; its falling edge marks the check word
//   data_in               header / payload / check word
//   fifo_full             selected output FIFO is full
//   detect_add, lfd_state, ld_state, laf_state, full_state
//                         one-hot FSM state decodes (at most one high)
//   rst_int_reg           FSM request to clear low_pkt_valid
//   dout                  word to the FIFO write port (registered)
//   err                   checksum mismatch on the last packet
//   len_err               payload count differs from the header length field
//   parity_done           check word compared, packet closed
//   low_pkt_valid         check word received
//   err_count             saturating count of packets with err or len_err
module router_reg_p #(
    parameter int DW          = 8,
    parameter int ADDR_W      = 2,
    parameter int PARITY_MODE = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [DW-1:0]    data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [DW-1:0]    dout,
    output logic             err,
    output logic             len_err,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic [CNT_W-1:0] err_count
);

    localparam int LEN_W = DW - ADDR_W;

    logic [DW-1:0]    r_hdr;
    logic [DW-1:0]    r_full_byte;
    logic [DW-1:0]    r_int_par;
    logic [DW-1:0]    r_pkt_par;
    logic [LEN_W:0]   r_pay_cnt;
    logic [DW-1:0]    r_dout;
    logic             r_err;
    logic             r_len_err;
    logic             r_parity_done;
    logic             r_parity_done_d;
    logic             r_low_pkt_valid;
    logic [CNT_W-1:0] r_err_count;

    logic [DW-1:0]    w_par_x;
    logic [DW-1:0]    w_par_next;
    logic             w_acc_pay;
    logic             w_acc;
    logic             w_cmp_fire;
    logic [LEN_W:0]   w_len_field;
    logic             w_err_next;
    logic             w_len_err_next;
    logic             w_set_done;

    always_comb begin
        w_par_x        = lfd_state ? r_hdr : data_in;
        w_par_next     = (PARITY_MODE == 1) ? (r_int_par + w_par_x) : (r_int_par ^ w_par_x);
        // Payload is counted/accumulated even while fifo_full parks it in
        // full_byte; only the FSM's full_state suppresses it, so a parked word
        // is never counted twice.
        w_acc_pay      = ld_state && pkt_valid && !full_state;
        w_acc          = lfd_state || w_acc_pay;
        // Compare fires once, in the cycle after parity_done rises.
        w_cmp_fire     = r_parity_done && !r_parity_done_d;
        w_len_field    = {1'b0, r_hdr[DW-1:ADDR_W]};
        w_err_next     = (r_int_par != r_pkt_par);
        w_len_err_next = (r_pay_cnt != w_len_field);
        w_set_done     = (ld_state && !fifo_full && !pkt_valid) ||
                         (laf_state && r_low_pkt_valid && !r_parity_done);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hdr           <= '0;
            r_full_byte     <= '0;
            r_int_par       <= '0;
            r_pkt_par       <= '0;
            r_pay_cnt       <= '0;
            r_dout          <= '0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
            r_parity_done   <= 1'b0;
            r_parity_done_d <= 1'b0;
            r_low_pkt_valid <= 1'b0;
            r_err_count     <= '0;
        end else begin
            if (detect_add && pkt_valid) begin
                r_hdr <= data_in;
            end

            if (lfd_state) begin
                r_dout <= r_hdr;
            end else if (ld_state && !fifo_full) begin
                r_dout <= data_in;
            end else if (laf_state) begin
                r_dout <= r_full_byte;
            end

            if (ld_state && fifo_full) begin
                r_full_byte <= data_in;
            end

            if (detect_add) begin
                r_int_par <= '0;
            end else if (w_acc) begin
                r_int_par <= w_par_next;
            end

            if (detect_add) begin
                r_pay_cnt <= '0;
            end else if (w_acc_pay && (r_pay_cnt != {(LEN_W+1){1'b1}})) begin
                r_pay_cnt <= r_pay_cnt + (LEN_W+1)'(1);
            end

            // Setting the check-word flag wins over the FSM clear request.
            if (ld_state && !pkt_valid && !r_low_pkt_valid) begin
                r_pkt_par       <= data_in;
                r_low_pkt_valid <= 1'b1;
            end else if (rst_int_reg) begin
                r_low_pkt_valid <= 1'b0;
            end

            if (detect_add) begin
                r_parity_done <= 1'b0;
            end else if (w_set_done) begin
                r_parity_done <= 1'b1;
            end
            r_parity_done_d <= r_parity_done;

            // A new header in the compare cycle wins over the flag write,
            // but the closed packet is still counted below.
            if (detect_add) begin
                r_err     <= 1'b0;
                r_len_err <= 1'b0;
            end else if (w_cmp_fire) begin
                r_err     <= w_err_next;
                r_len_err <= w_len_err_next;
            end

            if (w_cmp_fire && (w_err_next || w_len_err_next) &&
                (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign dout          = r_dout;
    assign err           = r_err;
    assign len_err       = r_len_err;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_router_reg_p.sv
// Testbench for router_reg_p. Two instances share one stimulus stream:
// u_a uses default parameters (8-bit, XOR, 8-bit counter), u_b uses
// DW=16, PARITY_MODE=1, CNT_W=2. The variable sel chooses which instance
// the monitor checks.
module tb_router_reg_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
    logic        laf_state, full_state, rst_int_reg;
    logic [15:0] data_in;
    logic        sel;

    logic [7:0]  dout_a;
    logic        err_a, len_err_a, pd_a, lpv_a;
    logic [7:0]  cnt_a;
    logic [15:0] dout_b;
    logic        err_b, len_err_b, pd_b, lpv_b;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    logic [9:0]  res_q[$];
    logic [15:0] pay[16];

    always #5 clk = ~clk;

    router_reg_p u_a (
        .clock(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in[7:0]),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout_a), .err(err_a), .len_err(len_err_a),
        .parity_done(pd_a), .low_pkt_valid(lpv_a), .err_count(cnt_a)
    );

    router_reg_p #(.DW(16), .ADDR_W(2), .PARITY_MODE(1), .CNT_W(2)) u_b (
        .clock(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout_b), .err(err_b), .len_err(len_err_b),
        .parity_done(pd_b), .low_pkt_valid(lpv_b), .err_count(cnt_b)
    );

    logic [15:0] w_dout;
    logic        w_err, w_len, w_pd, w_lpv;
    logic [7:0]  w_cnt;
    always_comb begin
        w_dout = sel ? dout_b    : {8'h00, dout_a};
        w_err  = sel ? err_b     : err_a;
        w_len  = sel ? len_err_b : len_err_a;
        w_pd   = sel ? pd_b      : pd_a;
        w_lpv  = sel ? lpv_b     : lpv_a;
        w_cnt  = sel ? {6'b0, cnt_b} : cnt_a;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic det, input logic lfd, input logic ld, input logic laf,
                       input logic fst, input logic pv, input logic ff, input logic rir,
                       input logic [15:0] d);
        detect_add  = det;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fst;
        pkt_valid   = pv;
        fifo_full   = ff;
        rst_int_reg = rir;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    function automatic logic [15:0] acc(input logic [15:0] a, input logic [15:0] b);
        return sel ? (a + b) : ((a ^ b) & 16'h00FF);
    endfunction

    // One packet: header, lfd, n payload words (optional stall at index
    // stall_at), check word XORed with chk_xor, then the closing idle cycles.
    task automatic send_pkt(input logic [15:0] h, input int n, input int stall_at,
                            input logic [15:0] chk_xor, input logic e_err,
                            input logic e_len, input logic [7:0] e_cnt);
        logic [15:0] m;
        logic [15:0] par;
        logic [15:0] chk;
        m   = sel ? 16'hFFFF : 16'h00FF;
        par = acc(16'h0, h);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, h);
        exp_q.push_back(h & m);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, h);
        for (int i = 0; i < n; i++) begin
            par = acc(par, pay[i]);
            exp_q.push_back(pay[i] & m);
            if (i == stall_at) begin
                cyc(0, 0, 1, 0, 0, 1, 1, 0, pay[i]);
                cyc(0, 0, 0, 1, 0, 1, 0, 0, 16'h0);
            end else begin
                cyc(0, 0, 1, 0, 0, 1, 0, 0, pay[i]);
            end
        end
        chk = (par ^ chk_xor) & m;
        exp_q.push_back(chk);
        res_q.push_back({e_err, e_len, e_cnt});
        cyc(0, 0, 1, 0, 0, 0, 0, 0, chk);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h0);
        idle();
        idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        m_wr = 1'b0, m_rst = 1'b0, m_det = 1'b0;
    logic        pd_prev = 1'b0, res_pend = 1'b0;
    logic [15:0] last_dout = 16'h0;

    always @(posedge clk) begin
        m_wr  <= lfd_state | (ld_state & ~fifo_full) | laf_state;
        m_rst <= reset;
        m_det <= detect_add;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        logic [9:0]  r;
        if (m_rst) begin
            check("rst_dout", w_dout, 0);
            check("rst_err", w_err, 0);
            check("rst_len_err", w_len, 0);
            check("rst_parity_done", w_pd, 0);
            check("rst_low_pkt_valid", w_lpv, 0);
            check("rst_err_count", w_cnt, 0);
        end else if (m_wr) begin
            if (exp_q.size() == 0) begin
                check("dout_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout", w_dout, e);
            end
        end else if (!reset) begin
            check("dout_hold", w_dout, last_dout);
        end

        if (m_det && !m_rst) begin
            check("clr_parity_done", w_pd, 0);
            check("clr_err", w_err, 0);
            check("clr_len_err", w_len, 0);
        end

        if (res_pend && !m_rst) begin
            if (res_q.size() == 0) begin
                check("result_unexpected", 1, 0);
            end else begin
                r = res_q.pop_front();
                check("err", w_err, r[9]);
                check("len_err", w_len, r[8]);
                check("err_count", w_cnt, r[7:0]);
            end
        end
        res_pend = w_pd && !pd_prev && !m_rst;
        if (w_pd && !pd_prev && !m_rst) check("lpv_at_done", w_lpv, 1);
        pd_prev   = w_pd;
        last_dout = w_dout;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        sel   = 1'b0;
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();

        // Good packet: header 8'h39 (len 14, addr 01), correct XOR check.
        for (int i = 0; i < 14; i++) pay[i] = 16'($urandom_range(0, 255));
        send_pkt(16'h0039, 14, -1, 16'h0000, 0, 0, 8'd0);
        // Same packet, inverted check byte.
        send_pkt(16'h0039, 14, -1, 16'h00FF, 1, 0, 8'd1);
        // Next good packet clears err; count stays 1.
        send_pkt(16'h0039, 14, -1, 16'h0000, 0, 0, 8'd1);
        // Stall on payload byte 5.
        for (int i = 0; i < 14; i++) pay[i] = 16'($urandom_range(0, 255));
        send_pkt(16'h0039, 14, 5, 16'h0000, 0, 0, 8'd1);
        // Header length 10 (8'h29), 12 bytes sent.
        for (int i = 0; i < 12; i++) pay[i] = 16'($urandom_range(0, 255));
        send_pkt(16'h0029, 12, -1, 16'h0000, 0, 1, 8'd2);

        // Switch to the 16-bit additive instance.
        reset = 1'b1;
        sel   = 1'b1;
        idle();
        reset = 1'b0;
        idle();
        pay[0] = 16'hFFFF;
        pay[1] = 16'h0002;
        // 9 + FFFF + 2 = 000A: good; 000B: bad.
        send_pkt(16'h0009, 2, -1, 16'h0000, 0, 0, 8'd0);
        send_pkt(16'h0009, 2, -1, 16'h0001, 1, 0, 8'd1);
        for (int k = 0; k < 4; k++) begin
            send_pkt(16'h0009, 2, -1, 16'hFFFF, 1, 0, (k < 1) ? 8'd2 : 8'd3);
        end

        // Reset mid-payload: everything zero next cycle, packet abandoned.
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 16'h0009);
        exp_q.push_back(16'h0009);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 16'h0009);
        exp_q.push_back(16'h1234);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 16'h1234);
        exp_q.push_back(16'h5678);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 16'h5678);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle();
        idle();

        for (int t = 0; t < 20 && (res_q.size() != 0 || exp_q.size() != 0); t++) idle();
        check("result_queue_drained", res_q.size(), 0);
        check("dout_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
